aircraft_agent: RTL and testbench
=================================

// Module: aircraft_agent
// PURPOSE
//  Pilot-side endpoint of the 9-bit ATC message link: one instance models one aircraft.
//  Issues a takeoff/landing REQUEST, waits for the controller's reply (HOLD/CLEAR/SAY_AGAIN/DIVERT),
//  occupies the granted runway, then sends DECLARE to free it. Drives the controller's rx side, consumes its tx side.
//  Message = {plane_id[3:0], msg_type[2:0], msg_action[1:0]}; msg_action = {dir (0 takeoff, 1 land), runway}.
//  msg_type: REQUEST=000 DECLARE=001 EMERGENCY=010 POSITION=011 CLEAR=100 HOLD=101 SAY_AGAIN=110 DIVERT=111.
// PARAMETERS
//  TIMEOUT     255  cycles in WAIT_REPLY/WAIT_CLEAR with no matching reply before re-sending REQUEST
//  MAX_RETRY   3    re-sends (SAY_AGAIN or timeout) allowed before giving up as diverted
//  USE_CYCLES  16   cycles the runway is held after CLEAR before DECLARE is sent
// PORTS
//  clock       in   1  system clock, all state on posedge
//  reset_n     in   1  asynchronous, active-low reset
//  my_id       in   4  this aircraft's plane_id; static while busy=1
//  start       in   1  1-cycle pulse: begin a request; ignored unless state is IDLE, DONE or DIVERTED
//  want_land   in   1  sampled with start: 1 = landing, 0 = takeoff
//  tx_data     out  9  message to controller
//  tx_valid    out  1  tx_data valid; held with tx_data stable until tx_ready
//  tx_ready    in   1  controller link accepts tx_data this cycle
//  rx_data     in   9  reply from controller
//  rx_valid    in   1  rx_data valid for this cycle (no backpressure; always consumed)
//  runway_busy out  1  aircraft occupies runway (USE state)
//  runway_id   out  1  runway granted by last CLEAR
//  busy        out  1  state not in {IDLE, DONE, DIVERTED}
//  done        out  1  state == DONE
//  diverted    out  1  state == DIVERTED
// BEHAVIOUR
//  Reset: state IDLE; tx_valid=0, tx_data=0, runway_busy=0, runway_id=0, busy=0, done=0, diverted=0;
//   retry count, timer, latched dir cleared. Reset mid-handshake drops tx_valid immediately (async).
//  States: IDLE, SEND_REQ, WAIT_REPLY, WAIT_CLEAR, USE, SEND_DECL, DONE, DIVERTED.
//  IDLE/DONE/DIVERTED + start: latch dir=want_land, retry=0 -> SEND_REQ next cycle.
//  SEND_REQ: tx_valid=1, tx_data={my_id,000,dir,0}. On tx_valid&tx_ready -> WAIT_REPLY, timer=0.
//  Reply matching: only rx_valid with rx_data[8:5]==my_id is acted on; all others ignored, timer keeps counting.
//  WAIT_REPLY, matching reply:
//   HOLD -> WAIT_CLEAR, timer=0.  CLEAR -> USE, runway_id=rx_data[0], timer=0.
//   DIVERT -> DIVERTED.  SAY_AGAIN or type 000-011 (malformed) -> retry path.
//  WAIT_CLEAR, matching reply: CLEAR -> USE as above; DIVERT -> DIVERTED; HOLD -> stay, timer=0;
//   SAY_AGAIN/malformed -> retry path.
//  Retry path (also timer reaching TIMEOUT): if retry==MAX_RETRY -> DIVERTED, else retry+=1 -> SEND_REQ.
//   Timer is 8+ bits, saturates; timeout fires on the cycle timer==TIMEOUT-1 with no matching reply.
//  USE: runway_busy=1 for exactly USE_CYCLES cycles, then -> SEND_DECL. rx ignored in USE.
//  SEND_DECL: tx_data={my_id,001,dir,runway_id}, tx_valid=1 until tx_ready -> DONE. Replies ignored.
//  DONE/DIVERTED: terminal, outputs steady; start restarts. start while busy=1 ignored.
//  Simultaneous rx_valid match and timeout in same cycle: reply wins.
//  tx_valid never asserted outside SEND_REQ/SEND_DECL; tx_data changes only when tx_valid=0 or after handshake.
//  Latency: start -> tx_valid = 1 cycle; matching CLEAR -> runway_busy = 1 cycle.
// TESTING
//  id=5, start, want_land=0, tx_ready=1 -> tx_data=9'b0101_000_00; reply {5,CLEAR,00} -> runway_busy 16 cyc,
//   then tx_data=9'b0101_001_00, done=1.
//  id=3 land, reply {3,HOLD}, 40 cyc later {3,CLEAR,11} -> runway_id=1, DECLARE=9'b0011_001_11.
//  id=2, replies {7,CLEAR} and {2,SAY_AGAIN} x3 -> 4 REQUESTs sent total; 4th SAY_AGAIN -> diverted=1.
//  id=9, no reply, TIMEOUT=20 -> REQUEST re-sent every ~21 cyc, diverted after 4 total sends.
//  tx_ready held 0 for 10 cyc in SEND_REQ -> tx_valid/tx_data stable 10 cyc; reset_n low mid-wait -> all outputs 0.
//  id=4 reply {4,DIVERT,00} in WAIT_REPLY -> diverted=1 next cycle; start then -> new REQUEST, diverted=0.

Source files
------------

// File: rtl/aircraft_agent.sv
// Pilot-side endpoint of the 9-bit ATC link: requests a runway, waits for the
// controller's reply, occupies the runway when cleared, then declares it free.
module aircraft_agent #(
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3,
  parameter int USE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] my_id,
  input  logic       start,
  input  logic       want_land,
  output logic [8:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [8:0] rx_data,
  input  logic       rx_valid,
  output logic       runway_busy,
  output logic       runway_id,
  output logic       busy,
  output logic       done,
  output logic       diverted
);

  // state      | meaning
  // IDLE       | never started since reset
  // SEND_REQ   | REQUEST offered on tx, waiting for tx_ready
  // WAIT_REPLY | REQUEST accepted, waiting for first controller reply
  // WAIT_CLEAR | told to HOLD, waiting for CLEAR
  // USE        | runway occupied for USE_CYCLES cycles
  // SEND_DECL  | DECLARE offered on tx, waiting for tx_ready
  // DONE       | runway released, terminal until next start
  // DIVERTED   | gave up or was diverted, terminal until next start
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SEND_REQ   = 3'd1;
  localparam logic [2:0] WAIT_REPLY = 3'd2;
  localparam logic [2:0] WAIT_CLEAR = 3'd3;
  localparam logic [2:0] USE        = 3'd4;
  localparam logic [2:0] SEND_DECL  = 3'd5;
  localparam logic [2:0] DONE       = 3'd6;
  localparam logic [2:0] DIVERTED   = 3'd7;

  localparam logic [2:0] MSG_REQUEST = 3'b000;
  localparam logic [2:0] MSG_DECLARE = 3'b001;
  localparam logic [2:0] MSG_CLEAR   = 3'b100;
  localparam logic [2:0] MSG_HOLD    = 3'b101;
  localparam logic [2:0] MSG_DIVERT  = 3'b111;

  localparam int TMAX = (TIMEOUT > USE_CYCLES) ? TIMEOUT : USE_CYCLES;
  localparam int TW   = ($clog2(TMAX + 1) > 8) ? $clog2(TMAX + 1) : 8;
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic          dir;

  logic       match;
  logic [2:0] rx_type;
  logic       timed_out;
  logic       use_end;
  logic       retry_max;
  logic       idle_like;
  logic       unused_rx;

  assign match     = rx_valid && (rx_data[8:5] == my_id);
  assign rx_type   = rx_data[4:2];
  assign timed_out = (timer == TW'(TIMEOUT - 1));
  assign use_end   = (timer == TW'(USE_CYCLES - 1));
  assign retry_max = (retry == RW'(MAX_RETRY));
  assign idle_like = (state == IDLE) || (state == DONE) || (state == DIVERTED);
  // The direction bit of a reply carries no information for the pilot side.
  assign unused_rx = rx_data[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      retry     <= '0;
      dir       <= 1'b0;
      runway_id <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, DIVERTED: begin
          if (start) begin
            dir   <= want_land;
            retry <= '0;
            state <= SEND_REQ;
          end
        end
        SEND_REQ: begin
          if (tx_ready) begin
            timer <= '0;
            state <= WAIT_REPLY;
          end
        end
        WAIT_REPLY, WAIT_CLEAR: begin
          // A matching reply always takes precedence over the timeout.
          if (match && rx_type == MSG_CLEAR) begin
            runway_id <= rx_data[0];
            timer     <= '0;
            state     <= USE;
          end else if (match && rx_type == MSG_DIVERT) begin
            state <= DIVERTED;
          end else if (match && rx_type == MSG_HOLD) begin
            timer <= '0;
            state <= WAIT_CLEAR;
          end else if (match || timed_out) begin
            if (retry_max) begin
              state <= DIVERTED;
            end else begin
              retry <= retry + 1'b1;
              state <= SEND_REQ;
            end
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        USE: begin
          if (use_end) state <= SEND_DECL;
          else         timer <= timer + 1'b1;
        end
        SEND_DECL: begin
          if (tx_ready) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    case (state)
      SEND_REQ: begin
        tx_valid = 1'b1;
        tx_data  = {my_id, MSG_REQUEST, dir, 1'b0};
      end
      SEND_DECL: begin
        tx_valid = 1'b1;
        tx_data  = {my_id, MSG_DECLARE, dir, runway_id};
      end
      default: ;
    endcase
  end

  assign runway_busy = (state == USE);
  assign busy        = !idle_like;
  assign done        = (state == DONE);
  assign diverted    = (state == DIVERTED);

endmodule

// File: tb/tb_aircraft_agent.sv
// Directed bench for aircraft_agent: expected tx messages are queued as
// stimulus is driven and checked against every tx handshake.
module tb_aircraft_agent;
  localparam int T_OUT = 50;
  localparam int USE_C = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] my_id = '0;
  logic       start = 1'b0;
  logic       want_land = 1'b0;
  logic [8:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [8:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       runway_busy, runway_id, busy, done, diverted;

  int vectors = 0;
  int miscompares = 0;
  int req_seen = 0;
  logic [8:0] exp_q[$];

  aircraft_agent #(.TIMEOUT(T_OUT), .MAX_RETRY(3), .USE_CYCLES(USE_C)) dut (
    .clock(clock), .reset_n(reset_n), .my_id(my_id), .start(start),
    .want_land(want_land), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .runway_busy(runway_busy), .runway_id(runway_id), .busy(busy),
    .done(done), .diverted(diverted)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] msg(input logic [3:0] id, input logic [2:0] t,
                                     input logic d, input logic rw);
    return {id, t, d, rw};
  endfunction

  // Scoreboard: every accepted tx message must be the oldest expected one.
  always @(negedge clock) begin
    if (reset_n && tx_valid && tx_ready) begin
      logic [8:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
      if (tx_data[4:2] == 3'b000) req_seen++;
      vectors++;
      assert (tx_data === e) else begin
        miscompares++;
        $error("FAIL tx_msg: observed=%b expected=%b", tx_data, e);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_rx(input logic [8:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] id, input logic land);
    my_id     = id;
    want_land = land;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  function automatic logic [6:0] outs();
    return {tx_valid, runway_busy, runway_id, busy, done, diverted, |tx_data};
  endfunction

  initial begin
    int n;
    int r0;

    // reset state
    repeat (2) tick();
    check("reset_outputs", 16'(outs()), 16'h0);
    reset_n = 1'b1;
    tick();

    // id=5 takeoff, CLEAR runway 0
    exp_q.push_back(msg(4'd5, 3'b000, 1'b0, 1'b0));
    do_start(4'd5, 1'b0);
    check("start_latency_tx_valid", 16'(tx_valid), 16'h1);
    check("busy_in_send_req", 16'(busy), 16'h1);
    tick();
    exp_q.push_back(msg(4'd5, 3'b001, 1'b0, 1'b0));
    send_rx(msg(4'd5, 3'b100, 1'b0, 1'b0));
    check("clear_latency_runway_busy", 16'(runway_busy), 16'h1);
    n = 0;
    while (runway_busy && n < 100) begin n++; tick(); end
    check("use_cycles", 16'(n), 16'(USE_C));
    check("decl_tx_valid", 16'(tx_valid), 16'h1);
    tick();
    check("done_after_decl", 16'({done, busy, tx_valid}), 16'b100);

    // id=3 landing, HOLD, foreign CLEAR ignored, CLEAR runway 1
    exp_q.push_back(msg(4'd3, 3'b000, 1'b1, 1'b0));
    do_start(4'd3, 1'b1);
    check("done_cleared_on_start", 16'(done), 16'h0);
    tick();
    send_rx(msg(4'd3, 3'b101, 1'b1, 1'b0));
    repeat (20) tick();
    send_rx(msg(4'd7, 3'b100, 1'b1, 1'b1));
    check("foreign_clear_ignored", 16'({runway_busy, busy}), 16'b01);
    repeat (19) tick();
    exp_q.push_back(msg(4'd3, 3'b001, 1'b1, 1'b1));
    send_rx(msg(4'd3, 3'b100, 1'b1, 1'b1));
    check("runway_id_granted", 16'({runway_busy, runway_id}), 16'b11);
    repeat (USE_C) tick();
    tick();
    check("done_id3", 16'(done), 16'h1);

    // id=2, three SAY_AGAINs then diverted on the fourth
    r0 = req_seen;
    exp_q.push_back(msg(4'd2, 3'b000, 1'b0, 1'b0));
    do_start(4'd2, 1'b0);
    tick();
    send_rx(msg(4'd7, 3'b100, 1'b0, 1'b0));
    check("other_plane_clear_ignored", 16'({runway_busy, busy}), 16'b01);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(msg(4'd2, 3'b000, 1'b0, 1'b0));
      send_rx(msg(4'd2, 3'b110, 1'b0, 1'b0));
      check("say_again_resend", 16'(tx_valid), 16'h1);
      tick();
    end
    send_rx(msg(4'd2, 3'b110, 1'b0, 1'b0));
    check("diverted_after_retries", 16'({diverted, busy, tx_valid}), 16'b100);
    check("request_count_say_again", 16'(req_seen - r0), 16'd4);

    // id=9, no reply: resend every T_OUT cycles, diverted after 4 sends
    r0 = req_seen;
    repeat (4) exp_q.push_back(msg(4'd9, 3'b000, 1'b0, 1'b0));
    do_start(4'd9, 1'b0);
    check("restart_clears_diverted", 16'(diverted), 16'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!tx_valid && n < 1000) begin tick(); n++; end
      check("timeout_period", 16'(n), 16'(T_OUT));
      tick();
    end
    n = 0;
    while (!diverted && n < 1000) begin tick(); n++; end
    check("timeout_to_diverted", 16'(n), 16'(T_OUT));
    check("request_count_timeout", 16'(req_seen - r0), 16'd4);

    // reply arriving on the timeout cycle wins
    exp_q.push_back(msg(4'd1, 3'b000, 1'b1, 1'b0));
    do_start(4'd1, 1'b1);
    tick();
    send_rx(msg(4'd1, 3'b101, 1'b1, 1'b0));
    repeat (T_OUT - 1) tick();
    exp_q.push_back(msg(4'd1, 3'b001, 1'b1, 1'b0));
    send_rx(msg(4'd1, 3'b100, 1'b1, 1'b0));
    check("reply_beats_timeout", 16'({runway_busy, tx_valid, runway_id}), 16'b100);
    repeat (USE_C + 1) tick();
    check("done_id1", 16'(done), 16'h1);

    // backpressure in SEND_REQ, then async reset mid-wait
    tx_ready = 1'b0;
    do_start(4'd6, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", 16'({tx_valid, tx_data}), 16'({1'b1, msg(4'd6, 3'b000, 1'b1, 1'b0)}));
      tick();
    end
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 16'(outs()), 16'h0);
    tx_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();

    // id=4 DIVERT, then restart
    exp_q.push_back(msg(4'd4, 3'b000, 1'b0, 1'b0));
    do_start(4'd4, 1'b0);
    tick();
    send_rx(msg(4'd4, 3'b111, 1'b0, 1'b0));
    check("divert_reply", 16'({diverted, busy}), 16'b10);
    exp_q.push_back(msg(4'd4, 3'b000, 1'b0, 1'b0));
    do_start(4'd4, 1'b0);
    check("restart_after_divert", 16'({diverted, tx_valid}), 16'b01);
    tick();
    tick();

    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
